// File: rtl/rv_trace_buffer_if.sv
// Trace buffer bundle: core capture inputs, head-entry stream and status.
// The slave modport is the buffer's view; the master modport is the driver/consumer side.
interface rv_trace_buffer_if #(
    parameter int unsigned Depth = 16
);
    localparam int unsigned Aw = $clog2(Depth);

    logic        cap_en;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic        clr_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_alu;
    logic [15:0] out_seq;
    logic [Aw:0] count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        stopped;

    modport slave (
        input  cap_en, trig_en, trig_pc, pc, instr, alu, clr_ovf, out_ready,
        output out_valid, out_pc, out_instr, out_alu, out_seq, count, full, empty,
        output overflow, drop_cnt, stopped
    );

    modport master (
        output cap_en, trig_en, trig_pc, pc, instr, alu, clr_ovf, out_ready,
        input  out_valid, out_pc, out_instr, out_alu, out_seq, count, full, empty,
        input  overflow, drop_cnt, stopped
    );
endinterface

// File: rtl/rv_trace_buffer.sv
// Retired-instruction trace FIFO with run/stop-on-trigger control, sequence
// numbering of every capture attempt and a saturating drop counter.
module rv_trace_buffer #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input logic              clk_i,
    input logic              rst_ni,
    rv_trace_buffer_if.slave trace_io
);

    localparam logic [Aw:0] DepthCnt = (Aw + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StRun, StStopped} state_e;

    state_e          state_q, state_d;
    logic            attempt, trig_hit, pop, push, drop, out_valid;
    logic [Aw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Aw:0]     count_q, count_d;
    logic [15:0]     seq_q, seq_d, drop_cnt_q, drop_cnt_d;
    logic            overflow_q, overflow_d;

    logic [31:0]     pc_mem_q    [Depth];
    logic [31:0]     instr_mem_q [Depth];
    logic [31:0]     alu_mem_q   [Depth];
    logic [15:0]     seq_mem_q   [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (trace_io.cap_en) state_d = StRun;
            StRun: begin
                if (!trace_io.cap_en) begin
                    state_d = StIdle;
                end else if (trig_hit) begin
                    state_d = StStopped;
                end
            end
            StStopped: if (!trace_io.cap_en) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        attempt          = (state_q == StRun) && trace_io.cap_en;
        trace_io.stopped = (state_q == StStopped);
    end

    assign trig_hit  = attempt && trace_io.trig_en && (trace_io.pc == trace_io.trig_pc);
    assign out_valid = (count_q != '0);

    always_comb begin
        pop        = out_valid && trace_io.out_ready;
        // A full buffer still accepts when the head leaves on the same edge.
        push       = attempt && ((count_q != DepthCnt) || pop);
        drop       = attempt && !push;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        seq_d      = attempt ? seq_q + 16'd1 : seq_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (trace_io.clr_ovf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (trace_io.clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is left uninitialised; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wptr_q]    <= trace_io.pc;
            instr_mem_q[wptr_q] <= trace_io.instr;
            alu_mem_q[wptr_q]   <= trace_io.alu;
            seq_mem_q[wptr_q]   <= seq_q;
        end
    end

    assign trace_io.out_valid = out_valid;
    assign trace_io.out_pc    = out_valid ? pc_mem_q[rptr_q] : '0;
    assign trace_io.out_instr = out_valid ? instr_mem_q[rptr_q] : '0;
    assign trace_io.out_alu   = out_valid ? alu_mem_q[rptr_q] : '0;
    assign trace_io.out_seq   = out_valid ? seq_mem_q[rptr_q] : '0;
    assign trace_io.count     = count_q;
    assign trace_io.full      = (count_q == DepthCnt);
    assign trace_io.empty     = !out_valid;
    assign trace_io.overflow  = overflow_q;
    assign trace_io.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Self-checking bench for rv_trace_buffer: queue scoreboard plus per-scenario tasks.
module tb_rv_trace_buffer;
    localparam int unsigned Depth = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_trace_buffer_if #(.Depth(Depth)) tif ();

    rv_trace_buffer #(.Depth(Depth)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .trace_io(tif)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [15:0] seq;
    } ent_t;

    ent_t        q[$];
    ent_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          st_m   = 0;   // 0 idle, 1 run, 2 stopped
    logic [15:0] seq_m  = '0;
    logic        pop_m, att_m;

    // Reference model: advances on each rising edge from the inputs held that cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            st_m  = 0;
            seq_m = '0;
        end else begin
            pop_m = (q.size() != 0) && tif.out_ready;
            att_m = (st_m == 1) && tif.cap_en;
            if (pop_m) void'(q.pop_front());
            if (att_m) begin
                if (q.size() < Depth) begin
                    mon_e.pc    = tif.pc;
                    mon_e.instr = tif.instr;
                    mon_e.alu   = tif.alu;
                    mon_e.seq   = seq_m;
                    q.push_back(mon_e);
                end
                seq_m = seq_m + 16'd1;
            end
            case (st_m)
                0: if (tif.cap_en) st_m = 1;
                1: begin
                    if (!tif.cap_en) st_m = 0;
                    else if (tif.trig_en && tif.pc == tif.trig_pc) st_m = 2;
                end
                default: if (!tif.cap_en) st_m = 0;
            endcase
        end
    end

    // Scoreboard compare on the falling edge, away from the update edge.
    always @(negedge clk) begin
        checks++;
        if (tif.count !== q.size()) begin
            errors++;
            $display("FAIL sb_count got %0d want %0d", tif.count, q.size());
        end
        checks++;
        if (tif.out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL sb_valid got %0b want %0b", tif.out_valid, q.size() != 0);
        end
        if (tif.out_valid && tif.out_ready && q.size() != 0) begin
            checks++;
            if (tif.out_pc !== q[0].pc || tif.out_instr !== q[0].instr ||
                tif.out_alu !== q[0].alu || tif.out_seq !== q[0].seq) begin
                errors++;
                $display("FAIL sb_entry got pc=%h seq=%h want pc=%h seq=%h",
                         tif.out_pc, tif.out_seq, q[0].pc, q[0].seq);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pc(input logic [31:0] p);
        tif.pc    = p;
        tif.instr = {p[15:0], 16'h0013};
        tif.alu   = ~p ^ 32'h1234_5678;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        tif.cap_en    = 1'b0;
        tif.trig_en   = 1'b0;
        tif.trig_pc   = '0;
        tif.clr_ovf   = 1'b0;
        tif.out_ready = 1'b0;
        drive_pc(32'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Arm in IDLE, then make n attempts with pc = 0, 4, 8, ...
    task automatic fill(input int n);
        tif.cap_en = 1'b1;
        drive_pc(32'h0);
        tick();
        for (int k = 0; k < n; k++) begin
            drive_pc(32'(4 * k));
            tick();
        end
        tif.cap_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", tif.out_valid); end
        checks++; if (tif.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", tif.empty); end
        checks++; if (tif.full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b want 0", tif.full); end
        checks++; if (tif.stopped !== 1'b0) begin errors++; $display("FAIL rst_stopped got %0b want 0", tif.stopped); end
        checks++; if (tif.out_seq !== 16'h0) begin errors++; $display("FAIL rst_seq got %h want 0", tif.out_seq); end
        checks++; if (tif.overflow !== 1'b0 || tif.drop_cnt !== 16'h0) begin errors++; $display("FAIL rst_ovf got %0b/%h want 0/0", tif.overflow, tif.drop_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        tif.out_ready = 1'b1;
        tif.cap_en    = 1'b1;
        drive_pc(32'h0);
        tick();
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_arm got %0b want 0", tif.out_valid); end
        for (int k = 0; k < 10; k++) begin
            drive_pc(32'(4 * k));
            tick();
            if (k == 0) begin
                checks++;
                if (tif.out_valid !== 1'b1 || tif.out_pc !== 32'h0 || tif.out_seq !== 16'h0) begin
                    errors++;
                    $display("FAIL stream_first got v=%0b pc=%h seq=%h want 1/0/0", tif.out_valid, tif.out_pc, tif.out_seq);
                end
            end
            checks++; if (tif.count > 1) begin errors++; $display("FAIL stream_count got %0d want <=1", tif.count); end
        end
        tif.cap_en = 1'b0;
        tick();
        tick();
        checks++; if (tif.empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %0b want 1", tif.empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        fill(20);
        checks++; if (tif.full !== 1'b1 || tif.count !== 5'd16) begin errors++; $display("FAIL ovf_full got %0b/%0d want 1/16", tif.full, tif.count); end
        checks++; if (tif.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", tif.overflow); end
        checks++; if (tif.drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drops got %0d want 4", tif.drop_cnt); end
        checks++; if (tif.out_pc !== 32'h0 || tif.out_seq !== 16'h0) begin errors++; $display("FAIL ovf_hold got %h/%h want 0/0", tif.out_pc, tif.out_seq); end
        tif.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (tif.out_seq !== 16'(i)) begin errors++; $display("FAIL ovf_drain_seq got %0d want %0d", tif.out_seq, i); end
            tick();
        end
        checks++; if (tif.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b want 0", tif.out_valid); end
        tif.out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        fill(16);
        tif.cap_en = 1'b1;
        tick();
        drive_pc(32'h100);
        tif.out_ready = 1'b1;
        tick();
        tif.out_ready = 1'b0;
        tif.cap_en    = 1'b0;
        checks++; if (tif.count !== 5'd16) begin errors++; $display("FAIL fpp_count got %0d want 16", tif.count); end
        checks++; if (tif.drop_cnt !== 16'd0 || tif.overflow !== 1'b0) begin errors++; $display("FAIL fpp_drops got %0d/%0b want 0/0", tif.drop_cnt, tif.overflow); end
        checks++; if (tif.out_seq !== 16'd1) begin errors++; $display("FAIL fpp_head got %0d want 1", tif.out_seq); end
        tick();
        tif.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (tif.out_seq !== 16'(i + 1)) begin errors++; $display("FAIL fpp_seq got %0d want %0d", tif.out_seq, i + 1); end
            tick();
        end
        tif.out_ready = 1'b0;
    endtask

    task automatic test_trigger();
        do_reset();
        tif.trig_en = 1'b1;
        tif.trig_pc = 32'h10;
        tif.cap_en  = 1'b1;
        drive_pc(32'h0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive_pc(32'(4 * k));
            tick();
            checks++; if (tif.stopped !== (k >= 4)) begin errors++; $display("FAIL trig_stopped k=%0d got %0b want %0b", k, tif.stopped, k >= 4); end
        end
        checks++; if (tif.count !== 5'd5) begin errors++; $display("FAIL trig_count got %0d want 5", tif.count); end
        tif.cap_en = 1'b0;
        tick();
        checks++; if (tif.stopped !== 1'b0) begin errors++; $display("FAIL trig_idle got %0b want 0", tif.stopped); end
        tif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tif.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL trig_pc got %h want %h", tif.out_pc, 4 * i); end
            tick();
        end
        tif.out_ready = 1'b0;
        tif.trig_en   = 1'b0;
    endtask

    task automatic test_drop_saturate();
        do_reset();
        fill(316);
        checks++; if (tif.drop_cnt !== 16'd300 || tif.overflow !== 1'b1) begin errors++; $display("FAIL sat_300 got %0d/%0b want 300/1", tif.drop_cnt, tif.overflow); end
        tif.clr_ovf = 1'b1;
        tick();
        tif.clr_ovf = 1'b0;
        checks++; if (tif.drop_cnt !== 16'd0 || tif.overflow !== 1'b0) begin errors++; $display("FAIL sat_clr got %0d/%0b want 0/0", tif.drop_cnt, tif.overflow); end
        tif.cap_en = 1'b1;
        tick();
        tif.clr_ovf = 1'b1;
        tick();
        tif.clr_ovf = 1'b0;
        checks++; if (tif.drop_cnt !== 16'd1 || tif.overflow !== 1'b1) begin errors++; $display("FAIL sat_clr_drop got %0d/%0b want 1/1", tif.drop_cnt, tif.overflow); end
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (i == 65532) begin
                checks++; if (tif.drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h want fffe", tif.drop_cnt); end
            end
        end
        checks++; if (tif.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max got %h want ffff", tif.drop_cnt); end
        tif.cap_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        fill(12);
        tif.out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (tif.count !== 5'd9) begin errors++; $display("FAIL mid_count got %0d want 9", tif.count); end
        rst_n = 1'b0;
        tick();
        checks++; if (tif.count !== 5'd0 || tif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst got %0d/%0b want 0/0", tif.count, tif.out_valid); end
        rst_n         = 1'b1;
        tif.out_ready = 1'b0;
        tif.cap_en    = 1'b1;
        drive_pc(32'h200);
        tick();
        tick();
        tif.cap_en = 1'b0;
        checks++; if (tif.out_valid !== 1'b1 || tif.out_seq !== 16'h0 || tif.out_pc !== 32'h200) begin
            errors++;
            $display("FAIL mid_restart got v=%0b seq=%h pc=%h want 1/0/200", tif.out_valid, tif.out_seq, tif.out_pc);
        end
        tif.out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        tif.cap_en    = 1'b0;
        tif.trig_en   = 1'b0;
        tif.trig_pc   = '0;
        tif.clr_ovf   = 1'b0;
        tif.out_ready = 1'b0;
        drive_pc(32'h0);
        test_reset();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_trigger();
        test_drop_saturate();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_trace_buffer.md
RV_TRACE_BUFFER -- requirements
Module: rv_trace_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of trace entries; power of two, 2..256.
REQ-002 Parameter AW, log2(DEPTH), storage address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on rising clk only.
REQ-005 cap_en  in  1  capture enable from bench/debug control.
REQ-006 trig_en  in  1  enables stop-on-trigger.
REQ-007 trig_pc  in  32  trigger PC value.
REQ-008 pc_in  in  32  core PC, one retired instruction per cycle.
REQ-009 instr_in  in  32  core instruction word for pc_in.
REQ-010 alu_in  in  32  core ALU result for pc_in.
REQ-011 out_ready  in  1  consumer accepts head entry.
REQ-012 clr_ovf  in  1  clears overflow and drop_cnt.
REQ-013 out_valid  out  1  head entry present.
REQ-014 out_pc, out_instr, out_alu  out  32 each  head entry fields.
REQ-015 out_seq  out  16  sequence number of head entry.
REQ-016 count  out  AW+1  entries held, 0..DEPTH.
REQ-017 full, empty  out  1 each  count==DEPTH, count==0.
REQ-018 overflow  out  1  sticky: at least one capture dropped.
REQ-019 drop_cnt  out  16  dropped captures, saturating.
REQ-020 stopped  out  1  high in STOPPED state.

Function
REQ-021 FSM states IDLE, RUN, STOPPED; capture attempt occurs only in a cycle where state==RUN and cap_en==1.
REQ-022 Transitions: IDLE->RUN when cap_en==1; RUN->IDLE when cap_en==0; RUN->STOPPED on a capture attempt with trig_en==1 and pc_in==trig_pc; STOPPED->IDLE when cap_en==0; all other cases hold state.
REQ-023 Triggering capture attempt is itself recorded (or dropped, if full); no attempts occur in STOPPED.
REQ-024 First capture attempt is the cycle after cap_en is sampled high in IDLE (one-cycle arm latency).
REQ-025 Each attempt carries seq = seq_ctr, and seq_ctr increments by 1 per attempt (recorded or dropped), wrapping 0xFFFF->0x0000; gaps in out_seq identify drops.
REQ-026 Pop occurs when out_valid==1 and out_ready==1; head advances on that edge.
REQ-027 Push occurs on an attempt when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-028 Attempt with count==DEPTH and no pop is dropped: overflow set to 1, drop_cnt incremented, saturating at 0xFFFF.
REQ-029 Simultaneous push and pop leaves count unchanged; read/write pointers wrap modulo DEPTH.
REQ-030 Entry pushed into an empty buffer is visible on out_* with out_valid=1 the following cycle (1-cycle latency); no same-cycle bypass.
REQ-031 out_* fields hold stable while out_valid==1 and out_ready==0.
REQ-032 out_* fields are don't-care while out_valid==0; out_valid equals !empty.
REQ-033 clr_ovf==1 clears overflow and drop_cnt next edge; a drop in the same cycle wins (overflow=1, drop_cnt=1).
REQ-034 cap_en deassertion never flushes stored entries; draining continues in any state.

Reset
REQ-035 reset==0 at a rising edge forces state=IDLE, count=0, pointers=0, seq_ctr=0, overflow=0, drop_cnt=0, regardless of in-flight push/pop.
REQ-036 Outputs after reset: out_valid=0, empty=1, full=0, stopped=0, count=0, out_seq=0.
REQ-037 Stored data need not be cleared; reset asserted mid-drain discards all entries.

Verification
REQ-038 Reset, cap_en=1 from cycle 0, pc_in=0,4,8,... per cycle, out_ready=1 -> first out_valid two cycles after cap_en, out_pc=0 with out_seq=0, then consecutive seq/PC, count<=1.
REQ-039 DEPTH=16, out_ready=0, 20 attempts -> full=1 after 16, overflow=1, drop_cnt=4, out_seq of drained entries 0..15.
REQ-040 Full buffer, out_ready=1 with one attempt in same cycle -> count stays 16, drop_cnt unchanged, new entry seq appended.
REQ-041 trig_en=1, trig_pc=0x0000_0010, PC stream 0,4,8,... -> entries 0x0..0x10 recorded, stopped=1, no further entries; cap_en=0 -> IDLE, stopped=0.
REQ-042 300 drops then clr_ovf=1 with no drop -> drop_cnt=0, overflow=0 next cycle; 70000 drops -> drop_cnt=0xFFFF.
REQ-043 reset=0 asserted with count=9 mid-drain -> next cycle count=0, out_valid=0, seq restarts at 0.
